// File: rtl/timeout_bank.sv
// timeout_bank: N independent W-bit down-counting timeout channels that share
// one free-running programmable prescaler. Each channel is one-shot or
// periodic, reports whether it is armed, pulses expire for one cycle on
// terminal count, and one channel at a time can be read back through a
// registered select port.
module timeout_bank #(
  parameter int W = 8,  // counter width per channel
  parameter int N = 4,  // number of channels
  parameter int P = 4,  // prescaler counter width
  parameter int S = 2   // readback select width, 2**S >= N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [P-1:0] div,
  input  logic [W-1:0] value,
  input  logic [N-1:0] load,
  input  logic [N-1:0] mode,
  input  logic [N-1:0] cancel,
  output logic [N-1:0] active,
  output logic [N-1:0] expire,
  input  logic [S-1:0] sel,
  output logic [W-1:0] count
);

  // ---------------------------------------------------------------------------
  // Shared prescaler. Using >= rather than == means that lowering div below
  // the current phase produces a tick on the very next cycle instead of
  // waiting for the counter to wrap all the way around.
  // ---------------------------------------------------------------------------
  logic [P-1:0] pc_reg;
  logic [P-1:0] pc_next;
  logic         tick;

  assign tick = (pc_reg >= div);

  // Next prescaler phase: restart after a tick, otherwise advance.
  always_comb begin
    pc_next = pc_reg + P'(1);
    if (tick) begin
      pc_next = '0;
    end
  end

  // Prescaler phase register; free-running, never touched by channel loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Per-channel counts gathered for the readback multiplexer.
  logic [W-1:0] cnt_all [N];

  // ---------------------------------------------------------------------------
  // Channel slices. Each channel owns its count, reload value, periodic flag
  // and expire pulse register; nothing here reads another channel's state.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      logic [W-1:0] cnt_reg;
      logic [W-1:0] cnt_next;
      logic [W-1:0] reload_reg;
      logic [W-1:0] reload_next;
      logic         per_reg;
      logic         per_next;
      logic         expire_reg;
      logic         expire_next;
      logic         at_terminal;

      // Terminal count is cnt==1 on a tick; cnt==0 means idle and never
      // decrements, so the counter cannot wrap.
      assign at_terminal = tick && (cnt_reg == W'(1));

      // Channel update in priority order: cancel, load, terminal, decrement.
      always_comb begin
        cnt_next    = cnt_reg;
        reload_next = reload_reg;
        per_next    = per_reg;
        expire_next = 1'b0;
        if (cancel[gi]) begin
          // Disarm wins over a simultaneous load and suppresses any expiry.
          cnt_next = '0;
        end else if (load[gi]) begin
          // A tick landing on the load edge is deliberately ignored so the
          // first decrement is always on a later tick.
          cnt_next    = value;
          reload_next = value;
          per_next    = mode[gi];
        end else if (at_terminal) begin
          expire_next = 1'b1;
          cnt_next    = per_reg ? reload_reg : '0;
        end else if (tick && (cnt_reg > W'(1))) begin
          cnt_next = cnt_reg - W'(1);
        end
      end

      // Channel state registers.
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_reg    <= '0;
          reload_reg <= '0;
          per_reg    <= 1'b0;
          expire_reg <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          reload_reg <= reload_next;
          per_reg    <= per_next;
          expire_reg <= expire_next;
        end
      end

      assign active[gi]  = (cnt_reg != '0);
      assign expire[gi]  = expire_reg;
      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Readback. Selects that do not name a channel read as zero.
  // ---------------------------------------------------------------------------
  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // Select the addressed channel's current count.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) begin
        count_next = cnt_all[i];
      end
    end
  end

  // Register the readback so count lags cnt by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_timeout_bank.sv
// tb_timeout_bank: directed stimulus for timeout_bank, checked every cycle
// against an integer model of the timer rules plus hand-computed literals.
module tb_timeout_bank;
  localparam int W = 8;
  localparam int N = 4;
  localparam int P = 4;
  localparam int S = 2;

  logic         clock;
  logic         reset;
  logic [P-1:0] div;
  logic [W-1:0] value;
  logic [N-1:0] load;
  logic [N-1:0] mode;
  logic [N-1:0] cancel;
  logic [N-1:0] active;
  logic [N-1:0] expire;
  logic [S-1:0] sel;
  logic [W-1:0] count;

  timeout_bank #(.W(W), .N(N), .P(P), .S(S)) dut (
    .clock (clock),
    .reset (reset),
    .div   (div),
    .value (value),
    .load  (load),
    .mode  (mode),
    .cancel(cancel),
    .active(active),
    .expire(expire),
    .sel   (sel),
    .count (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Integer model of the timer rules.
  int       m_pc = 0;
  int       m_cnt [N];
  int       m_rel [N];
  bit       m_per [N];
  bit [N-1:0] m_exp = '0;
  int       m_count = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_pc    <= 0;
      m_exp   <= '0;
      m_count <= 0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= 0;
        m_rel[i] <= 0;
        m_per[i] <= 1'b0;
      end
    end else begin
      m_pc    <= (m_pc >= int'(div)) ? 0 : m_pc + 1;
      m_count <= (int'(sel) < N) ? m_cnt[sel] : 0;
      for (int i = 0; i < N; i++) begin
        m_exp[i] <= 1'b0;
        if (cancel[i]) begin
          m_cnt[i] <= 0;
        end else if (load[i]) begin
          m_cnt[i] <= int'(value);
          m_rel[i] <= int'(value);
          m_per[i] <= mode[i];
        end else if (m_pc >= int'(div) && m_cnt[i] == 1) begin
          m_exp[i] <= 1'b1;
          m_cnt[i] <= m_per[i] ? m_rel[i] : 0;
        end else if (m_pc >= int'(div) && m_cnt[i] > 1) begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
    end
  end

  function automatic int model_active();
    int a = 0;
    for (int i = 0; i < N; i++) begin
      if (m_cnt[i] != 0) a = a | (1 << i);
    end
    return a;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cyc_active", int'(active), model_active());
      check("cyc_expire", int'(expire), int'(m_exp));
      check("cyc_count",  int'(count),  m_count);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  int pulses [8];
  int npulse;
  int bad_cnt;

  initial begin
    reset = 1'b1; load = '1; value = 8'h10; mode = '0; cancel = '0;
    div = '0; sel = '0;

    // Reset dominance.
    step();
    cmp_en = 1'b1;
    $display("[%0t] reset with load=1111 value=0x10", $time);
    check("rst_active", int'(active), 0);
    check("rst_expire", int'(expire), 0);
    check("rst_count",  int'(count),  0);
    reset = 1'b0; load = '0;
    repeat (5) step();
    check("rst_later_active", int'(active), 0);

    // One-shot, div=0, value=3 on channel 0.
    sel = 2'd0; value = 8'd3; mode = 4'b0000; load = 4'b0001;
    step();
    load = '0;
    $display("[%0t] one-shot ch0 value=3 div=0", $time);
    check("os_active_arm", int'(active[0]), 1);
    check("os_count_k",  int'(count), 0);
    step();
    check("os_count_k1", int'(count), 3);
    check("os_exp_k1",   int'(expire[0]), 0);
    step();
    check("os_count_k2", int'(count), 2);
    step();
    check("os_count_k3", int'(count), 1);
    check("os_exp_k3",   int'(expire[0]), 1);
    check("os_active_k3", int'(active[0]), 0);
    step();
    check("os_count_k4", int'(count), 0);
    check("os_exp_k4",   int'(expire[0]), 0);

    // Periodic, div=2, value=2 on channel 1: one pulse every 6 clocks.
    div = 4'd2; sel = 2'd1; value = 8'd2; mode = 4'b0010; load = 4'b0010;
    step();
    load = '0;
    $display("[%0t] periodic ch1 value=2 div=2", $time);
    npulse = 0; bad_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (expire[1] && npulse < 8) begin
        pulses[npulse] = c;
        npulse++;
      end
      if (active[1] !== 1'b1) bad_cnt++;
    end
    check("per_enough_pulses", int'(npulse >= 5), 1);
    check("per_first_latency", int'(pulses[0] >= 4 && pulses[0] <= 6), 1);
    for (int j = 0; j < 4; j++) begin
      check("per_interval", pulses[j+1] - pulses[j], 6);
    end
    check("per_active_drops", bad_cnt, 0);
    cancel = 4'b0010;
    step();
    cancel = '0;
    check("per_cancelled", int'(active[1]), 0);

    // Cancel beats a simultaneous load.
    div = 4'd0; sel = 2'd2; value = 8'd5; mode = 4'b0000;
    load = 4'b0100; cancel = 4'b0100;
    step();
    load = '0; cancel = '0;
    $display("[%0t] cancel+load ch2 value=5", $time);
    check("cl_active", int'(active[2]), 0);
    bad_cnt = 0;
    repeat (8) begin
      step();
      if (expire[2]) bad_cnt++;
    end
    check("cl_no_expire", bad_cnt, 0);

    // Cancel exactly at cnt=1 on a tick cycle.
    value = 8'd2; load = 4'b0100;
    step();
    load = '0;
    step();
    cancel = 4'b0100;
    step();
    cancel = '0;
    $display("[%0t] cancel ch2 at terminal count", $time);
    check("ct_expire", int'(expire[2]), 0);
    check("ct_active", int'(active[2]), 0);
    step();
    check("ct_expire_late", int'(expire[2]), 0);

    // Re-arm channel 3 while running.
    sel = 2'd3; value = 8'd6; mode = 4'b1000; load = 4'b1000;
    step();
    load = '0;
    step();
    step();
    check("ra_count_5", int'(count), 5);
    value = 8'd7; load = 4'b1000;
    step();
    load = '0;
    $display("[%0t] re-arm ch3 at cnt=4 with value=7", $time);
    check("ra_count_old", int'(count), 4);
    step();
    check("ra_count_7", int'(count), 7);
    repeat (5) step();
    check("ra_exp_early", int'(expire[3]), 0);
    step();
    check("ra_exp_on_time", int'(expire[3]), 1);

    // Zero load leaves the channel idle.
    value = 8'd0; load = 4'b1000;
    step();
    load = '0;
    $display("[%0t] zero load ch3", $time);
    check("zl_active", int'(active[3]), 0);
    bad_cnt = 0;
    repeat (20) begin
      step();
      if (expire[3]) bad_cnt++;
    end
    check("zl_no_expire", bad_cnt, 0);

    // Independence: staggered loads of value 4 give consecutive pulses.
    cancel = '1;
    step();
    cancel = '0;
    div = 4'd0; value = 8'd4; mode = 4'b0000;
    for (int i = 0; i < N; i++) begin
      load = 4'(1 << i);
      step();
    end
    load = '0;
    $display("[%0t] independence ch0..3 staggered value=4", $time);
    step();
    check("ind_exp0", int'(expire), 1);
    step();
    check("ind_exp1", int'(expire), 2);
    step();
    check("ind_exp2", int'(expire), 4);
    step();
    check("ind_exp3", int'(expire), 8);
    step();
    check("ind_exp_none", int'(expire), 0);
    check("ind_all_idle", int'(active), 0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timeout_bank.md
Name: timeout_bank

Overview:
- Multi-channel timeout timer bank: N independent down-counters of W bits sharing one programmable prescaler.
- Each channel runs either one-shot or periodic (auto-reload), flags when armed, and emits a one-cycle expire pulse.
- Generalised successor of the single-channel timeout timer; used by protocol engines and watchdog logic that need several concurrent timeouts.

Parameters:
W, 8, counter width per channel
N, 4, number of channels
P, 4, prescaler counter width
S, 2, channel-select width for readback (2**S >= N)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
div  input  P  prescaler divisor; tick every div+1 clocks
value  input  W  load value applied to every channel whose load bit is set
load  input  N  per-channel load/arm strobe
mode  input  N  per-channel mode sampled on load: 1 = periodic, 0 = one-shot
cancel  input  N  per-channel disarm strobe
active  output  N  channel i armed (cnt[i] != 0)
expire  output  N  registered one-cycle pulse when channel i reaches terminal count
sel  input  S  readback channel select
count  output  W  registered count of channel sel

Behaviour:
- Reset (synchronous, priority over everything): prescaler counter pc=0; all cnt, reload and per cleared; active=0, expire=0, count=0.
- Prescaler:
  - tick is high in a cycle when pc >= div; that edge sets pc to 0, otherwise pc increments.
  - div=0 gives a tick every cycle.
  - Lowering div below the current pc causes a tick on the next cycle, with no wrap-around stall.
  - pc is free-running and is not resynchronised by load.
- Per-channel state: cnt[W], reload[W], per; active[i] = (cnt[i] != 0), derived from registers.
- Per-channel update at each clock edge, in priority order:
  1. cancel[i]: cnt=0; expire[i] not asserted. Cancel wins over a simultaneous load.
  2. load[i]: cnt=value, reload=value, per=mode[i]. A tick in the same cycle is ignored for that channel. value=0 leaves the channel idle with no expire.
  3. tick && cnt!=0 && cnt==1: expire[i]=1 for the following cycle. If per, cnt=reload; else cnt=0.
  4. tick && cnt>1: cnt=cnt-1.
  5. Otherwise hold.
- expire[i] is 0 in every cycle not covered by rule 3. Pulses on multiple channels in the same cycle are independent.
- Latency:
  - With div=0, a load of v at edge k gives expire high for the cycle after edge k+v.
  - With div=d, the first decrement occurs at the first tick after the load edge, so expiry follows between (v-1)(d+1)+1 and v(d+1) clocks after the load edge.
- Periodic mode:
  - After each expire, cnt reloads to the stored reload value.
  - The period is exactly reload ticks, and expire recurs with no idle tick.
  - A load while running re-arms with the new value and mode immediately.
- Reloading or cancelling a channel never affects other channels or the prescaler.
- count is cnt[sel] registered with 1-cycle latency. sel >= N returns 0.
- No arithmetic wraps: cnt never decrements from 0.

Test Plan:
- Reset dominance: reset=1 together with load=4'b1111, value=8'h10 → after the edge, active=0, expire=0, count=0; a tick arriving later has no effect.
- One-shot, div=0: load[0] with value=3, mode=0 at edge k → count reads 3,2,1,0 across edges k+1..k+4 (one cycle lag); expire[0] is high only in the cycle after edge k+3; active[0] falls in the same cycle.
- Periodic with prescaler: div=2, load[1] with value=2, mode=1 → expire[1] pulses every 6 clocks for at least 4 periods; active[1] stays 1 throughout.
- Cancel vs load: in the same cycle as load[2] (value=5), assert cancel[2] → active[2]=0 and no expire. Separately, cancel at cnt=1 on a tick cycle → no expire.
- Re-arm and zero load: channel 3 running at cnt=4, load value=7 → count returns to 7 and the period restarts. Load with value=0 → active=0 and no expire ever.
- Independence: all four channels loaded with values 1..4, div=0, same edge → expire pulses on channels 0..3 in four consecutive cycles; each pulse lasts one cycle and the other channels are undisturbed.
